// File: rtl/qs_fifo_flow.sv
// qs_fifo_flow: synchronous FIFO with occupancy count, almost-full/empty
// thresholds, registered pop data with a valid strobe, sticky
// overflow/underflow flags and synchronous flush. DEPTH may be any value >= 2.
//
// Optional feature macro: QS_FIFO_FWFT_EN (first-word-fall-through). When it
// is defined the head entry is presented combinationally and pop_i is an
// acknowledge. When it is undefined, pop data arrives one cycle after an
// accepted pop.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-high reset
//   flush_i        synchronous clear of contents, pointers, count and error flags
//   push_i         write request, push_data_i is the write data
//   pop_i          read request (acknowledge in FWFT mode)
//   pop_data_o     read data
//   pop_valid_o    pop_data_o holds data from an accepted pop
//   count_o        occupancy, 0..DEPTH
//   full_o         count == DEPTH
//   empty_o        count == 0
//   almost_full_o  count >= AF_LVL
//   almost_empty_o count <= AE_LVL
//   overflow_o     sticky: a push was rejected
//   underflow_o    sticky: a pop was rejected
module qs_fifo_flow #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 6,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          pop_data_o,
  output logic                       pop_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Pointers carry the wrap bit in the MSB: {wrap, index}.
  logic [PTR_W:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, udf_q;
  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic empty, full, push_acc, pop_acc;

  // Index wraps at DEPTH-1 (not at a power of 2), toggling the wrap bit.
  function automatic logic [PTR_W:0] ptr_inc(input logic [PTR_W:0] p);
    if (p[PTR_W-1:0] == PTR_W'(DEPTH - 1))
      return {~p[PTR_W], {PTR_W{1'b0}}};
    else
      return {p[PTR_W], p[PTR_W-1:0] + PTR_W'(1)};
  endfunction

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]) && (wr_q[PTR_W] != rd_q[PTR_W]);

  // Flush wins over both requests. A push into a full FIFO is still taken
  // when a pop frees a slot in the same cycle.
  assign pop_acc  = ~flush_i & pop_i & ~empty;
  assign push_acc = ~flush_i & push_i & (~full | pop_acc);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_acc) wr_d = ptr_inc(wr_q);
      if (pop_acc)  rd_d = ptr_inc(rd_q);
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (flush_i) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else begin
        if (push_i & ~push_acc) ovf_q <= 1'b1;
        if (pop_i & empty)      udf_q <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_q[PTR_W-1:0]] <= push_data_i;
  end

`ifdef QS_FIFO_FWFT_EN
  assign pop_data_o  = mem_q[rd_q[PTR_W-1:0]];
  assign pop_valid_o = ~empty;
`else
  logic [DATA_W-1:0] pop_data_q;
  logic              pop_valid_q;

  // On push+pop into a full FIFO both hit the same slot; the read sees the
  // old entry because the write lands at the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= pop_acc;
      if (pop_acc) pop_data_q <= mem_q[rd_q[PTR_W-1:0]];
    end
  end

  assign pop_data_o  = pop_data_q;
  assign pop_valid_o = pop_valid_q;
`endif

  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= CNT_W'(AF_LVL));
  assign almost_empty_o = (count_q <= CNT_W'(AE_LVL));
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_qs_fifo_flow.sv
// Scoreboarded bench for qs_fifo_flow at DATA_W=8, DEPTH=6, AF_LVL=5, AE_LVL=1.
// Stimulus pushes the hand-written expected pop data into sb; a negedge
// monitor pops sb whenever pop_valid_o is high.
module tb_qs_fifo_flow;
  logic       clk = 1'b0;
  logic       reset, flush_i, push_i, pop_i;
  logic [7:0] push_data_i, pop_data_o;
  logic       pop_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
  logic       overflow_o, underflow_o;
  logic [2:0] count_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  qs_fifo_flow #(.DATA_W(8), .DEPTH(6), .AF_LVL(5), .AE_LVL(1)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .push_i(push_i),
    .push_data_i(push_data_i), .pop_i(pop_i), .pop_data_o(pop_data_o),
    .pop_valid_o(pop_valid_o), .count_o(count_o), .full_o(full_o),
    .empty_o(empty_o), .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o), .overflow_o(overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid strobe must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (pop_valid_o) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_unexpected: got %0h expected no pop_valid", pop_data_o);
        end else begin
          chk("pop_data", pop_data_o, sb.pop_front());
        end
      end
    end
  end

  // One clock: drive inputs, take the edge, release inputs 1ns later.
  task automatic cyc(input bit p, input logic [7:0] d, input bit q,
                     input bit ev, input logic [7:0] e, input bit fl = 1'b0);
    push_i = p; push_data_i = d; pop_i = q; flush_i = fl;
    if (ev) sb.push_back(e);
    @(posedge clk); #1;
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_empty"}, empty_o, 1);
    chk({tag, "_full"}, full_o, 0);
    chk({tag, "_af"}, almost_full_o, 0);
    chk({tag, "_ae"}, almost_empty_o, 1);
    chk({tag, "_ovf"}, overflow_o, 0);
    chk({tag, "_udf"}, underflow_o, 0);
    chk({tag, "_pvalid"}, pop_valid_o, 0);
    chk({tag, "_pdata"}, pop_data_o, 0);
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; push_data_i = 8'h00;
    #12;
    chk_reset_vals("rst");
    reset = 1'b0;

    // 1: fill 0x11..0x16, check thresholds, drain in order.
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 8'(8'h10 + k), 0, 0, 0);
      chk("t1_count", count_o, k);
      chk("t1_af", almost_full_o, (k >= 5) ? 1 : 0);
      chk("t1_ae", almost_empty_o, (k <= 1) ? 1 : 0);
    end
    chk("t1_full", full_o, 1);
    for (int k = 1; k <= 6; k++) cyc(0, 0, 1, 1, 8'(8'h10 + k));
    cyc(0, 0, 0, 0, 0);
    chk("t1_empty", empty_o, 1);

    // 2: full with simultaneous push+pop for 10 cycles, wrap-around.
    for (int k = 1; k <= 6; k++) cyc(1, 8'(8'h30 + k), 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1, 8'(8'h20 + k), 1, 1, (k < 6) ? 8'(8'h31 + k) : 8'(8'h20 + k - 6));
      chk("t2_count", count_o, 6);
      chk("t2_ovf", overflow_o, 0);
    end
    for (int k = 4; k <= 9; k++) cyc(0, 0, 1, 1, 8'(8'h20 + k));
    cyc(0, 0, 0, 0, 0);
    chk("t2_empty", empty_o, 1);

    // 3: overflow on full, 0xAA dropped, flush clears (flush beats push/pop).
    for (int k = 1; k <= 6; k++) cyc(1, 8'(8'h40 + k), 0, 0, 0);
    cyc(1, 8'hAA, 0, 0, 0);
    chk("t3_ovf", overflow_o, 1);
    chk("t3_count", count_o, 6);
    cyc(0, 0, 0, 0, 0);
    chk("t3_ovf_sticky", overflow_o, 1);
    for (int k = 1; k <= 4; k++) cyc(0, 0, 1, 1, 8'(8'h40 + k));
    cyc(1, 8'hBB, 1, 0, 0, 1'b1);
    chk("t3_fl_count", count_o, 0);
    chk("t3_fl_empty", empty_o, 1);
    chk("t3_fl_ovf", overflow_o, 0);
    chk("t3_fl_pvalid", pop_valid_o, 0);

    // 4: pop on empty -> underflow, data held.
    cyc(0, 0, 1, 0, 0);
    chk("t4_udf", underflow_o, 1);
    chk("t4_pvalid", pop_valid_o, 0);
    chk("t4_pdata", pop_data_o, 8'h44);
    chk("t4_count", count_o, 0);

    // 5: push+pop on empty -> only push accepted.
    cyc(0, 0, 0, 0, 0, 1'b1);
    chk("t5_udf_clr", underflow_o, 0);
    cyc(1, 8'h55, 1, 0, 0);
    chk("t5_count", count_o, 1);
    chk("t5_pvalid", pop_valid_o, 0);
    chk("t5_udf", underflow_o, 1);
    cyc(0, 0, 1, 1, 8'h55);
    cyc(0, 0, 0, 0, 0);

    // 6: async reset with 3 entries held.
    for (int k = 1; k <= 3; k++) cyc(1, 8'(8'h60 + k), 0, 0, 0);
    chk("t6_count_pre", count_o, 3);
    #2 reset = 1'b1;
    #1 chk_reset_vals("arst");
    #1 reset = 1'b0;
    cyc(1, 8'h77, 0, 0, 0);
    cyc(0, 0, 1, 1, 8'h77);
    cyc(0, 0, 0, 0, 0);
    chk("t6_empty", empty_o, 1);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
